// File: rtl/rc4_sched_pkg.sv
// Shared types for the RC4 key-search phase scheduler.
// FAULT exists only when RC4_SCHED_WDOG_EN is defined.
package rc4_sched_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_GO, S_INIT_GRD, S_INIT_RUN,
    S_KSA_GO,  S_KSA_GRD,  S_KSA_RUN,
    S_PRGA_GO, S_PRGA_GRD, S_PRGA_RUN,
    S_NEXT_KEY,
    S_FOUND, S_EXHAUST
`ifdef RC4_SCHED_WDOG_EN
    , S_FAULT
`endif
  } sched_state_e;

  typedef enum logic [1:0] {GNT_NONE, GNT_INIT, GNT_KSA, GNT_PRGA} grant_e;

endpackage

// File: rtl/rc4_smem_mux.sv
// S-memory port mux: forwards exactly one client bus, or all zeros when
// nobody owns the port.
module rc4_smem_mux
  import rc4_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  grant_e            gnt,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic              init_wren,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [DATA_W-1:0] ksa_data,
  input  logic              ksa_wren,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] prga_data,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren
);

  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    case (gnt)
      GNT_INIT: begin mem_addr = init_addr; mem_data = init_data; mem_wren = init_wren; end
      GNT_KSA:  begin mem_addr = ksa_addr;  mem_data = ksa_data;  mem_wren = ksa_wren;  end
      GNT_PRGA: begin mem_addr = prga_addr; mem_data = prga_data; mem_wren = prga_wren; end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_phase_sched.sv
// RC4 key-search sequencer: S-init -> KSA -> PRGA per candidate key, owns the
// S-memory port. Optional per-phase watchdog: define RC4_SCHED_WDOG_EN.
module rc4_phase_sched
  import rc4_sched_pkg::*;
#(
  parameter int               KEY_W       = 24,
  parameter logic [KEY_W-1:0] KEY_MAX     = KEY_W'(24'h3FFFFF),
  parameter int               ADDR_W      = ADDR_W_DEF,
  parameter int               DATA_W      = DATA_W_DEF,
  parameter int               WDOG_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  output logic              busy,
  output logic              found,
  output logic              not_found,
  output logic              fault,
  output logic [KEY_W-1:0]  key,
  output logic              init_start,
  output logic              ksa_start,
  output logic              prga_start,
  input  logic              init_done,
  input  logic              ksa_done,
  input  logic              prga_done,
  input  logic              prga_pass,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic [DATA_W-1:0] ksa_data,
  input  logic [DATA_W-1:0] prga_data,
  input  logic              init_wren,
  input  logic              ksa_wren,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren
);

  sched_state_e     state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  grant_e           gnt;
  logic             wdog_trip;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    gnt        = GNT_NONE;
    init_start = 1'b0;
    ksa_start  = 1'b0;
    prga_start = 1'b0;
    case (state_q)
      S_IDLE, S_FOUND, S_EXHAUST
`ifdef RC4_SCHED_WDOG_EN
      , S_FAULT
`endif
      : if (go) begin
          state_d = S_INIT_GO;
          key_d   = '0;
        end
      S_INIT_GO:  begin gnt = GNT_INIT; init_start = 1'b1; state_d = S_INIT_GRD; end
      S_INIT_GRD: begin gnt = GNT_INIT; state_d = S_INIT_RUN; end
      S_INIT_RUN: begin gnt = GNT_INIT; if (init_done) state_d = S_KSA_GO; end
      S_KSA_GO:   begin gnt = GNT_KSA; ksa_start = 1'b1; state_d = S_KSA_GRD; end
      S_KSA_GRD:  begin gnt = GNT_KSA; state_d = S_KSA_RUN; end
      S_KSA_RUN:  begin gnt = GNT_KSA; if (ksa_done) state_d = S_PRGA_GO; end
      S_PRGA_GO:  begin gnt = GNT_PRGA; prga_start = 1'b1; state_d = S_PRGA_GRD; end
      S_PRGA_GRD: begin gnt = GNT_PRGA; state_d = S_PRGA_RUN; end
      S_PRGA_RUN: begin
        gnt = GNT_PRGA;
        if (prga_done) begin
          if (prga_pass)             state_d = S_FOUND;
          else if (key_q == KEY_MAX) state_d = S_EXHAUST;
          else                       state_d = S_NEXT_KEY;
        end
      end
      S_NEXT_KEY: begin key_d = key_q + 1'b1; state_d = S_INIT_GO; end
      default:    state_d = S_IDLE;
    endcase
`ifdef RC4_SCHED_WDOG_EN
    if (wdog_trip) state_d = S_FAULT;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
    end
  end

`ifdef RC4_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              is_go, is_run, run_done;

  always_comb begin
    is_go    = (state_q == S_INIT_GO) || (state_q == S_KSA_GO) || (state_q == S_PRGA_GO);
    is_run   = 1'b0;
    run_done = 1'b0;
    case (state_q)
      S_INIT_RUN: begin is_run = 1'b1; run_done = init_done; end
      S_KSA_RUN:  begin is_run = 1'b1; run_done = ksa_done;  end
      S_PRGA_RUN: begin is_run = 1'b1; run_done = prga_done; end
      default: ;
    endcase
    wdog_d = wdog_q;
    if (is_go)       wdog_d = '0;
    else if (is_run) wdog_d = wdog_q + 1'b1;
    // Trips on the last allowed RUN cycle so FAULT follows exactly WDOG_CYCLES RUN cycles.
    wdog_trip = is_run && !run_done && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end

  assign fault = (state_q == S_FAULT);
  assign busy  = !(state_q inside {S_IDLE, S_FOUND, S_EXHAUST, S_FAULT});
`else
  assign wdog_trip = 1'b0;
  assign fault     = 1'b0;
  assign busy      = !(state_q inside {S_IDLE, S_FOUND, S_EXHAUST});
  // WDOG_CYCLES is inert without the watchdog; referenced only as a sanity guard.
  if (WDOG_CYCLES < 1) begin : g_wdog_cfg_bad
  end
`endif

  assign found     = (state_q == S_FOUND);
  assign not_found = (state_q == S_EXHAUST);
  assign key       = key_q;

  rc4_smem_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .gnt       (gnt),
    .init_addr (init_addr),
    .init_data (init_data),
    .init_wren (init_wren),
    .ksa_addr  (ksa_addr),
    .ksa_data  (ksa_data),
    .ksa_wren  (ksa_wren),
    .prga_addr (prga_addr),
    .prga_data (prga_data),
    .prga_wren (prga_wren),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_wren  (mem_wren)
  );

endmodule

// File: tb/tb_rc4_phase_sched.sv
// Directed bench for rc4_phase_sched: dut0 uses default KEY_MAX, dut1 uses
// KEY_MAX=3 / WDOG_CYCLES=16. Stub clients raise done 3 cycles after start.
module tb_rc4_phase_sched;

  localparam logic [7:0] A0 = 8'h11, A1 = 8'h22, A2 = 8'h33;
  localparam logic [7:0] D0 = 8'hA1, D1 = 8'hB2, D2 = 8'hC3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  go = '0;
  logic [1:0]  busy, found, not_found, fault, mem_wren, pass;
  logic [23:0] key [2];
  logic [7:0]  mem_addr [2];
  logic [7:0]  mem_data [2];
  logic [1:0][2:0] st, dn;
  logic [1:0][2:0] hang = '0;
  logic [1:0]  stale = '0;
  int          pass_key [2] = '{-1, -1};

  int scnt [2][3], nst [2][3], win [2][3];
  logic [1:0][2:0] drop;
  int bsy [2], bad [2], ord [2], last [2];
  int b_nst [2][3], b_win [2][3], b_bsy [2], b_bad [2], b_ord [2];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  rc4_phase_sched dut0 (
    .clk(clk), .reset(rst), .go(go[0]), .busy(busy[0]), .found(found[0]),
    .not_found(not_found[0]), .fault(fault[0]), .key(key[0]),
    .init_start(st[0][0]), .ksa_start(st[0][1]), .prga_start(st[0][2]),
    .init_done(dn[0][0]), .ksa_done(dn[0][1]), .prga_done(dn[0][2]), .prga_pass(pass[0]),
    .init_addr(A0), .ksa_addr(A1), .prga_addr(A2),
    .init_data(D0), .ksa_data(D1), .prga_data(D2),
    .init_wren(1'b1), .ksa_wren(1'b1), .prga_wren(1'b1),
    .mem_addr(mem_addr[0]), .mem_data(mem_data[0]), .mem_wren(mem_wren[0])
  );

  rc4_phase_sched #(.KEY_MAX(24'd3), .WDOG_CYCLES(16)) dut1 (
    .clk(clk), .reset(rst), .go(go[1]), .busy(busy[1]), .found(found[1]),
    .not_found(not_found[1]), .fault(fault[1]), .key(key[1]),
    .init_start(st[1][0]), .ksa_start(st[1][1]), .prga_start(st[1][2]),
    .init_done(dn[1][0]), .ksa_done(dn[1][1]), .prga_done(dn[1][2]), .prga_pass(pass[1]),
    .init_addr(A0), .ksa_addr(A1), .prga_addr(A2),
    .init_data(D0), .ksa_data(D1), .prga_data(D2),
    .init_wren(1'b1), .ksa_wren(1'b1), .prga_wren(1'b1),
    .mem_addr(mem_addr[1]), .mem_data(mem_data[1]), .mem_wren(mem_wren[1])
  );

  always_comb begin
    pass[0] = (pass_key[0] >= 0) && (key[0] == 24'(pass_key[0]));
    pass[1] = (pass_key[1] >= 0) && (key[1] == 24'(pass_key[1]));
  end

  // Stub clients: done is a level; normally cleared by start, in stale mode
  // held through the guard cycle.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++)
      for (int p = 0; p < 3; p++) begin
        if (rst) begin
          scnt[g][p] <= 0; dn[g][p] <= 1'b0; drop[g][p] <= 1'b0;
        end else if (st[g][p]) begin
          scnt[g][p] <= 3; drop[g][p] <= stale[g];
          if (!stale[g]) dn[g][p] <= 1'b0;
        end else begin
          if (drop[g][p]) begin dn[g][p] <= 1'b0; drop[g][p] <= 1'b0; end
          if (scnt[g][p] == 1 && !hang[g][p]) dn[g][p] <= 1'b1;
          if (scnt[g][p] != 0) scnt[g][p] <= scnt[g][p] - 1;
        end
      end
  end

  function automatic int client_of(input logic [7:0] a, input logic [7:0] d);
    if (a == A0 && d == D0) return 0;
    if (a == A1 && d == D1) return 1;
    if (a == A2 && d == D2) return 2;
    return -1;
  endfunction

  // Every client always writes, so mem_* reveals the granted client each cycle.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (busy[g]) bsy[g] <= bsy[g] + 1;
      if (mem_wren[g]) begin
        if (client_of(mem_addr[g], mem_data[g]) < 0 || !busy[g]) bad[g] <= bad[g] + 1;
        else win[g][client_of(mem_addr[g], mem_data[g])] <= win[g][client_of(mem_addr[g], mem_data[g])] + 1;
      end else if (mem_addr[g] != 8'h0 || mem_data[g] != 8'h0) bad[g] <= bad[g] + 1;
      if ($countones(st[g]) > 1) ord[g] <= ord[g] + 1;
      for (int p = 0; p < 3; p++)
        if (st[g][p]) begin
          nst[g][p] <= nst[g][p] + 1;
          if (p == 0 ? !(last[g] == -1 || last[g] == 2) : (last[g] != p - 1)) ord[g] <= ord[g] + 1;
          last[g] <= p;
        end
      if (st[g] == 3'b000 && !busy[g]) last[g] <= -1;
    end
  end

  task automatic snap(input int g);
    for (int p = 0; p < 3; p++) begin b_nst[g][p] = nst[g][p]; b_win[g][p] = win[g][p]; end
    b_bsy[g] = bsy[g]; b_bad[g] = bad[g]; b_ord[g] = ord[g];
  endtask

  task automatic pulse_go(input int g);
    @(negedge clk) go[g] = 1'b1;
    @(negedge clk) go[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!busy[g]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_cmp++; if ({busy[g], found[g], not_found[g], fault[g]} !== 4'b0000) begin
        n_bad++; $display("FAIL reset_flags[%0d]: got %b want 0000", g, {busy[g], found[g], not_found[g], fault[g]}); end
      n_cmp++; if (key[g] !== 24'd0) begin n_bad++; $display("FAIL reset_key[%0d]: got %0d want 0", g, key[g]); end
      n_cmp++; if (st[g] !== 3'b000) begin n_bad++; $display("FAIL reset_start[%0d]: got %b want 000", g, st[g]); end
      n_cmp++; if ({mem_wren[g], mem_addr[g], mem_data[g]} !== 17'd0) begin
        n_bad++; $display("FAIL reset_mem[%0d]: got %b/%h/%h want 0/00/00", g, mem_wren[g], mem_addr[g], mem_data[g]); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_found;
    bit ok;
    pass_key[0] = 0; snap(0);
    pulse_go(0);
    n_cmp++; if ({busy[0], st[0]} !== 4'b1001) begin n_bad++; $display("FAIL go_latency: busy/start got %b want 1001", {busy[0], st[0]}); end
    wait_idle(0, 200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL found_timeout: got busy want idle"); end
    n_cmp++; if ({found[0], not_found[0]} !== 2'b10) begin n_bad++; $display("FAIL found_flags: got %b want 10", {found[0], not_found[0]}); end
    n_cmp++; if (key[0] !== 24'd0) begin n_bad++; $display("FAIL found_key: got %0d want 0", key[0]); end
    for (int p = 0; p < 3; p++) begin
      n_cmp++; if (nst[0][p] - b_nst[0][p] !== 1) begin n_bad++; $display("FAIL found_starts[%0d]: got %0d want 1", p, nst[0][p] - b_nst[0][p]); end
      n_cmp++; if (win[0][p] - b_win[0][p] !== 5) begin n_bad++; $display("FAIL found_window[%0d]: got %0d want 5", p, win[0][p] - b_win[0][p]); end
    end
    n_cmp++; if (bsy[0] - b_bsy[0] !== 15) begin n_bad++; $display("FAIL found_busy_cycles: got %0d want 15", bsy[0] - b_bsy[0]); end
    n_cmp++; if ({bad[0] - b_bad[0], ord[0] - b_ord[0]} !== 64'd0) begin
      n_bad++; $display("FAIL found_grant_order: bad %0d order %0d want 0/0", bad[0] - b_bad[0], ord[0] - b_ord[0]); end
  endtask

  task automatic test_retry;
    bit ok;
    pass_key[0] = 5; snap(0);
    pulse_go(0);
    repeat (40) @(negedge clk);
    pulse_go(0);
    wait_idle(0, 400, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL retry_timeout: got busy want idle"); end
    n_cmp++; if ({found[0], key[0]} !== {1'b1, 24'd5}) begin n_bad++; $display("FAIL retry_result: found %b key %0d want 1 key 5", found[0], key[0]); end
    n_cmp++; if (nst[0][0] - b_nst[0][0] !== 6) begin n_bad++; $display("FAIL retry_init_starts: got %0d want 6", nst[0][0] - b_nst[0][0]); end
    n_cmp++; if (win[0][2] - b_win[0][2] !== 30) begin n_bad++; $display("FAIL retry_prga_window: got %0d want 30", win[0][2] - b_win[0][2]); end
    n_cmp++; if (bsy[0] - b_bsy[0] !== 95) begin n_bad++; $display("FAIL retry_busy_cycles: got %0d want 95", bsy[0] - b_bsy[0]); end
    n_cmp++; if ({bad[0] - b_bad[0], ord[0] - b_ord[0]} !== 64'd0) begin
      n_bad++; $display("FAIL retry_grant_order: bad %0d order %0d want 0/0", bad[0] - b_bad[0], ord[0] - b_ord[0]); end
  endtask

  task automatic test_exhaust;
    bit ok;
    pass_key[1] = -1; snap(1);
    pulse_go(1);
    wait_idle(1, 300, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL exhaust_timeout: got busy want idle"); end
    n_cmp++; if ({not_found[1], found[1], fault[1]} !== 3'b100) begin n_bad++; $display("FAIL exhaust_flags: got %b want 100", {not_found[1], found[1], fault[1]}); end
    n_cmp++; if (key[1] !== 24'd3) begin n_bad++; $display("FAIL exhaust_key: got %0d want 3", key[1]); end
    n_cmp++; if (nst[1][0] - b_nst[1][0] !== 4) begin n_bad++; $display("FAIL exhaust_iters: got %0d want 4", nst[1][0] - b_nst[1][0]); end
    n_cmp++; if (bsy[1] - b_bsy[1] !== 63) begin n_bad++; $display("FAIL exhaust_busy_cycles: got %0d want 63", bsy[1] - b_bsy[1]); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({not_found[1], busy[1], key[1]} !== {2'b10, 24'd3}) begin
      n_bad++; $display("FAIL exhaust_hold: nf/busy %b key %0d want 10 key 3", {not_found[1], busy[1]}, key[1]); end
    pass_key[1] = 1; snap(1);
    pulse_go(1);
    n_cmp++; if ({not_found[1], key[1]} !== 25'd0) begin n_bad++; $display("FAIL exhaust_go_clear: nf %b key %0d want 0 key 0", not_found[1], key[1]); end
    wait_idle(1, 200, ok);
    n_cmp++; if ({ok, found[1], key[1]} !== {2'b11, 24'd1}) begin
      n_bad++; $display("FAIL exhaust_rerun: ok %b found %b key %0d want 1 1 key 1", ok, found[1], key[1]); end
    n_cmp++; if (bsy[1] - b_bsy[1] !== 31) begin n_bad++; $display("FAIL exhaust_rerun_cycles: got %0d want 31", bsy[1] - b_bsy[1]); end
  endtask

  task automatic test_stale_done;
    bit ok;
    stale[0] = 1'b1; pass_key[0] = 0; snap(0);
    pulse_go(0);
    wait_idle(0, 200, ok);
    n_cmp++; if ({ok, found[0], key[0]} !== {2'b11, 24'd0}) begin
      n_bad++; $display("FAIL stale_result: ok %b found %b key %0d want 1 1 key 0", ok, found[0], key[0]); end
    for (int p = 0; p < 3; p++) begin
      n_cmp++; if (win[0][p] - b_win[0][p] !== 5) begin n_bad++; $display("FAIL stale_window[%0d]: got %0d want 5", p, win[0][p] - b_win[0][p]); end
    end
    n_cmp++; if (bsy[0] - b_bsy[0] !== 15) begin n_bad++; $display("FAIL stale_busy_cycles: got %0d want 15", bsy[0] - b_bsy[0]); end
    stale[0] = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    pass_key[0] = 2;
    pulse_go(0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (key[0] == 24'd1 && st[0][1]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL midrst_reach_ksa: got timeout want ksa_start at key 1"); end
    repeat (2) @(negedge clk);
    n_cmp++; if ({mem_wren[0], mem_addr[0]} !== {1'b1, A1}) begin
      n_bad++; $display("FAIL midrst_ksa_grant: got %b/%h want 1/%h", mem_wren[0], mem_addr[0], A1); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({mem_wren[0], mem_addr[0], mem_data[0]} !== 17'd0) begin
      n_bad++; $display("FAIL midrst_mem: got %b/%h/%h want 0/00/00", mem_wren[0], mem_addr[0], mem_data[0]); end
    n_cmp++; if ({busy[0], found[0], key[0]} !== 26'd0) begin
      n_bad++; $display("FAIL midrst_state: busy %b found %b key %0d want 0 0 0", busy[0], found[0], key[0]); end
    rst = 1'b0;
    pass_key[0] = 0; snap(0);
    pulse_go(0);
    wait_idle(0, 200, ok);
    n_cmp++; if ({ok, found[0], key[0]} !== {2'b11, 24'd0}) begin
      n_bad++; $display("FAIL midrst_restart: ok %b found %b key %0d want 1 1 key 0", ok, found[0], key[0]); end
    n_cmp++; if (bsy[0] - b_bsy[0] !== 15) begin n_bad++; $display("FAIL midrst_busy_cycles: got %0d want 15", bsy[0] - b_bsy[0]); end
  endtask

`ifdef RC4_SCHED_WDOG_EN
  task automatic test_wdog;
    bit ok;
    hang[1] = 3'b010; pass_key[1] = 0;
    pulse_go(1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (st[1][1]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wdog_reach_ksa: got timeout want ksa_start"); end
    repeat (17) @(negedge clk);
    n_cmp++; if ({fault[1], busy[1]} !== 2'b01) begin n_bad++; $display("FAIL wdog_early: fault/busy got %b want 01", {fault[1], busy[1]}); end
    @(negedge clk);
    n_cmp++; if ({fault[1], busy[1], key[1]} !== {2'b10, 24'd0}) begin
      n_bad++; $display("FAIL wdog_fault: fault/busy %b key %0d want 10 key 0", {fault[1], busy[1]}, key[1]); end
    hang[1] = 3'b000;
    pulse_go(1);
    n_cmp++; if ({fault[1], busy[1]} !== 2'b01) begin n_bad++; $display("FAIL wdog_go_clear: fault/busy got %b want 01", {fault[1], busy[1]}); end
    wait_idle(1, 200, ok);
    n_cmp++; if ({ok, found[1], fault[1]} !== 3'b110) begin n_bad++; $display("FAIL wdog_recover: ok/found/fault got %b want 110", {ok, found[1], fault[1]}); end
  endtask
`endif

  initial begin
    for (int g = 0; g < 2; g++) begin
      bsy[g] = 0; bad[g] = 0; ord[g] = 0; last[g] = -1;
      for (int p = 0; p < 3; p++) begin nst[g][p] = 0; win[g][p] = 0; end
    end
  end

  initial begin
    test_reset;
    test_found;
    test_retry;
    test_exhaust;
    test_stale_done;
    test_reset_mid;
`ifdef RC4_SCHED_WDOG_EN
    test_wdog;
`endif
    n_cmp++; if (bad[0] + bad[1] !== 0) begin n_bad++; $display("FAIL global_grant: stray mem cycles %0d want 0", bad[0] + bad[1]); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
